// File: rtl/dmem_responder_if.sv
// Request/response channel bundle between the memory-access stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// little-endian 64-bit doubleword storage with RV64 sizing and extension.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem_q [DEPTH];
    logic        mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [63:0] mem_wdata_d;

    logic [1:0]  size;
    logic [2:0]  lane;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        acc_err;
    logic [63:0] cur_word;
    logic [63:0] shifted;
    logic [63:0] load_val;
    logic [63:0] byte_mask;
    logic [63:0] store_word;

    // Access decode works only on the captured request, so bus changes
    // during WAIT cannot leak into the result.
    always_comb begin
        size    = funct3_q[1:0];
        lane    = addr_q[2:0];
        illegal = we_q ? funct3_q[2] : (funct3_q == 3'b111);

        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr_q[0];
            2'd2:    misaligned = |addr_q[1:0];
            default: misaligned = |addr_q[2:0];
        endcase

        out_of_range = {3'b000, addr_q[63:3]} >= 64'(DEPTH);
        acc_err      = illegal | misaligned | out_of_range;

        mem_idx  = addr_q[IDX_W+2:3];
        cur_word = mem_q[mem_idx];
        shifted  = cur_word >> {lane, 3'b000};

        case (funct3_q)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  load_val = shifted;
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = '0;
        endcase

        case (size)
            2'd0:    byte_mask = 64'h0000_0000_0000_00FF;
            2'd1:    byte_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = '1;
        endcase
        byte_mask  = byte_mask << {lane, 3'b000};
        store_word = (cur_word & ~byte_mask) | ((wdata_q << {lane, 3'b000}) & byte_mask);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_wdata_d = store_word;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? '0 : load_val;
                    mem_we  = we_q && !acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain; mem_we can only be
    // high in WAIT, which reset forces away immediately.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata_d;
        end
    end

    assign bus.req_ready = rst && (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
